baud_rate_gen: RTL and testbench
================================

Name: baud_rate_gen

Overview:
Programmable UART baud generator with an oversampling tick. It is the runtime-configurable successor to the fixed-divisor tick counter. It derives an oversample tick (os_tick), a bit-rate tick (bit_tick) and a mid-bit sample tick (mid_tick) from clk, using a bus-loadable integer+fractional divisor. It sits between the Wishbone register file (divisor writes) and the UART TX/RX engines. RX uses restart to phase-align to the start-bit edge.

Parameters:
DIV_W, 16, integer divisor width
FRAC_W, 4, fractional divisor width (units of 1/2^FRAC_W clk)
OVERSAMPLE, 16, os_ticks per bit; power of two, >=4
RESET_DIV, 27, integer divisor after reset (50 MHz / (115200*16) ~ 27.13)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
en  in  1  count enable; low = freeze all counters
restart  in  1  sync pulse: realign phase to 0
div_int  in  DIV_W  new integer divisor
div_frac  in  FRAC_W  new fractional divisor
div_load  in  1  one-cycle strobe capturing div_int/div_frac
div_pending  out  1  shadow divisor captured, not yet active
os_tick  out  1  one-cycle oversample tick
bit_tick  out  1  one-cycle tick, last os_tick of each bit
mid_tick  out  1  one-cycle tick at bit centre
os_phase  out  clog2(OVERSAMPLE)  current oversample index

Behaviour:
- State: cnt[DIV_W], os_phase, acc[FRAC_W], act_int, act_frac, shadow regs, div_pending.
- Reset values: cnt=0, os_phase=0, acc=0, act_int=RESET_DIV, act_frac=0, div_pending=0. All tick outputs 0 while reset is high.
- period = act_int + carry, where carry = carry-out of (acc + act_frac). div_int values 0 or 1 are clamped to 2 on capture.
- os_tick = en & ~restart & (cnt == period-1). It is a combinational decode of registers plus en/restart.
- On os_tick: cnt<=0, acc<=acc+act_frac (mod 2^FRAC_W), os_phase<=os_phase+1 (wraps OVERSAMPLE-1 -> 0). Otherwise, when en=1, cnt<=cnt+1.
- bit_tick = os_tick & (os_phase == OVERSAMPLE-1). mid_tick = os_tick & (os_phase == OVERSAMPLE/2-1).
- Latency: with en=1 from the first cycle after reset release (cycle 0), os_tick fires on cycles RESET_DIV-1, 2*RESET_DIV-1, and so on.
- en=0: cnt/acc/os_phase hold and no ticks. Counting resumes from the held cnt.
- restart (priority over en): next cycle cnt=0, acc=0, os_phase=0. No ticks are asserted in the restart cycle.
- Divisor update:
  - div_load copies the inputs to the shadow registers and sets div_pending.
  - The shadow is applied (act_* <= shadow, div_pending<=0) on an apply event: any os_tick cycle, any restart cycle, or any cycle with en=0.
  - The period that is in progress always completes with the old divisor. Ticks never glitch or shorten.
- div_load coinciding with an apply event: the incoming div_int/div_frac are applied directly and div_pending stays 0.
- Back-to-back div_load before an apply event: last write wins.
- Reset mid-period: all state returns to reset values immediately (asynchronous); the shadow divisor is discarded.

Optional Feature:
FRAC_DIV_EN.
- Defined: fractional accumulator present; average period = act_int + act_frac/2^FRAC_W.
- Undefined: acc and act_frac are not implemented, div_frac is ignored, and period = act_int exactly.

Decomposition:
- Package baud_pkg:
  - DEFAULT_OVERSAMPLE, DEFAULT_RESET_DIV, DEFAULT_DIV_W, DEFAULT_FRAC_W
  - clog2-derived OS_W constant
  - a divisor struct typedef {int, frac}
- Natural sub-module: baud_frac_acc (FRAC_W accumulator: add-on-tick, carry-out, sync clear). It is instantiated only under FRAC_DIV_EN.

Test Plan:
- Reset, en=1, defaults, no load -> os_tick every 27 cycles (first at cycle 26); bit_tick every 432 cycles; mid_tick on the os_tick with os_phase=7.
- FRAC_DIV_EN, load div_int=27, div_frac=2, restart -> over 16 os_ticks, two periods are 28 and fourteen are 27; 16 ticks span 434 cycles.
- div_load 10 when cnt=5 (div 27) -> div_pending=1 until the os_tick at cnt=26, then 0. The following os_ticks are 10 cycles apart.
- Restart when os_phase=9, cnt=13 -> no tick that cycle; next os_tick 27 cycles later with os_phase 0->1; bit_tick 432 cycles after restart.
- en=0 for 50 cycles at cnt=20 (div 27) -> no ticks, os_phase held; os_tick 6 cycles after en rises. A div_load of 5 during en=0 is applied the next cycle (div_pending clears).
- Load div_int=1 -> os_tick every 2 cycles. Async reset asserted mid-period -> os_phase=0, div_pending=0, ticks 0 immediately; after release, period 27 again.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and types for the UART baud generator.
package baud_pkg;

  localparam int DEFAULT_DIV_W      = 16;
  localparam int DEFAULT_FRAC_W     = 4;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_RESET_DIV  = 27;

  localparam int OS_W = $clog2(DEFAULT_OVERSAMPLE);

  typedef struct packed {
    logic [DEFAULT_DIV_W-1:0]  int_part;
    logic [DEFAULT_FRAC_W-1:0] frac;
  } baud_div_t;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: adds frac on each tick and exposes the carry-out
// that stretches the current oversample period by one clock.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_W = DEFAULT_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              tick,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  assign carry = sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable UART baud generator: oversample, bit and mid-bit ticks from a shadowed
// integer divisor. Define FRAC_DIV_EN to add the fractional divisor accumulator.
module baud_rate_gen
  import baud_pkg::*;
#(
  parameter int DIV_W      = DEFAULT_DIV_W,
  parameter int FRAC_W     = DEFAULT_FRAC_W,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int RESET_DIV  = DEFAULT_RESET_DIV
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          restart,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          div_pending,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int PW = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] sh_int_q, sh_int_d;
  logic             pending_q, pending_d;
  logic             carry;
  logic [DIV_W:0]   period_m1;
  logic             tick;
  logic             apply;

  // Divisors below 2 cannot produce a one-cycle tick pulse, so they are raised to 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_W'(2)) ? DIV_W'(2) : v;
  endfunction

`ifdef FRAC_DIV_EN
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .tick  (tick),
    .frac  (act_frac_q),
    .carry (carry)
  );
`else
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign carry           = 1'b0;
`endif

  assign period_m1 = {1'b0, act_int_q} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
  assign tick      = en & ~restart & ({1'b0, cnt_q} == period_m1);
  // New divisors only take effect at a period boundary or while the counter is frozen.
  assign apply     = tick | restart | ~en;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + PW'(1);
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    act_int_d = act_int_q;
    sh_int_d  = sh_int_q;
    pending_d = pending_q;
`ifdef FRAC_DIV_EN
    act_frac_d = act_frac_q;
    sh_frac_d  = sh_frac_q;
`endif
    if (apply) begin
      pending_d = 1'b0;
      if (div_load) begin
        act_int_d = clamp_div(div_int);
`ifdef FRAC_DIV_EN
        act_frac_d = div_frac;
`endif
      end else if (pending_q) begin
        act_int_d = sh_int_q;
`ifdef FRAC_DIV_EN
        act_frac_d = sh_frac_q;
`endif
      end
    end else if (div_load) begin
      sh_int_d  = clamp_div(div_int);
      pending_d = 1'b1;
`ifdef FRAC_DIV_EN
      sh_frac_d = div_frac;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      phase_q   <= '0;
      act_int_q <= DIV_W'(RESET_DIV);
      sh_int_q  <= DIV_W'(RESET_DIV);
      pending_q <= 1'b0;
`ifdef FRAC_DIV_EN
      act_frac_q <= '0;
      sh_frac_q  <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      act_int_q <= act_int_d;
      sh_int_q  <= sh_int_d;
      pending_q <= pending_d;
`ifdef FRAC_DIV_EN
      act_frac_q <= act_frac_d;
      sh_frac_q  <= sh_frac_d;
`endif
    end
  end

  assign os_tick     = tick;
  assign bit_tick    = tick & (phase_q == PW'(OVERSAMPLE - 1));
  assign mid_tick    = tick & (phase_q == PW'(OVERSAMPLE / 2 - 1));
  assign os_phase    = phase_q;
  assign div_pending = pending_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Self-checking bench for baud_rate_gen: expected tick cycles/phases are queued per
// scenario and matched against every tick the DUT produces.
module tb_baud_rate_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int W      = 38;  // {cycle[31:0], phase[3:0], bit, mid}

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              restart;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              div_pending;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic [3:0]        os_phase;

  int         cyc      = 0;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       mon_en   = 1'b0;
  logic [W-1:0] exp_q[$];

  baud_rate_gen dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .restart     (restart),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .div_pending (div_pending),
    .os_tick     (os_tick),
    .bit_tick    (bit_tick),
    .mid_tick    (mid_tick),
    .os_phase    (os_phase)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_tick(input int c, input int ph);
    logic [31:0] cc;
    logic [3:0]  p4;
    cc = c;
    p4 = 4'(ph);
    exp_q.push_back({cc, p4, (p4 == 4'd15), (p4 == 4'd7)});
  endtask

  // advance to the point just after the edge that starts cycle c
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic end_window();
    mon_en = 1'b0;
    check("missed_ticks", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(output int base);
    mon_en   = 1'b0;
    reset    = 1'b1;
    en       = 1'b1;
    restart  = 1'b0;
    div_load = 1'b0;
    div_int  = '0;
    div_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ticks", {os_tick, bit_tick, mid_tick}, 0);
    check("rst_phase", os_phase, 0);
    check("rst_pending", div_pending, 0);
    reset  = 1'b0;
    base   = cyc;
    mon_en = 1'b1;
  endtask

  // scoreboard: every tick seen must match the head of the expected queue
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (mon_en && !reset && (os_tick || bit_tick || mid_tick)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", {os_tick, bit_tick, mid_tick}, 0);
      end else begin
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e[37:6]);
        check("tick_phase", os_phase, e[5:2]);
        check("os_tick", os_tick, 1);
        check("bit_tick", bit_tick, e[1]);
        check("mid_tick", mid_tick, e[0]);
      end
    end
  end

  initial begin
    int b, b2, r, c0, x;

    // default divisor, free running for two bit times
    do_reset(b);
    for (int k = 0; k < 32; k++) push_tick(b + 26 + 27 * k, k % 16);
    goto(b + 26 + 27 * 31 + 2);
    end_window();

    // load while a period is in progress
    do_reset(b);
    push_tick(b + 26, 0);
    for (int k = 1; k < 6; k++) push_tick(b + 26 + 10 * k, k);
    goto(b + 5);
    div_int  = 10;
    div_load = 1'b1;
    goto(b + 6);
    div_load = 1'b0;
    check("pend_set", div_pending, 1);
    goto(b + 26);
    check("pend_hold", div_pending, 1);
    goto(b + 27);
    check("pend_clear", div_pending, 0);
    goto(b + 26 + 50 + 2);
    end_window();

    // restart mid-period and on a would-be tick cycle
    do_reset(b);
    for (int k = 0; k < 9; k++) push_tick(b + 26 + 27 * k, k);
    r  = b + 256;
    c0 = r + 1;
    for (int k = 0; k < 16; k++) push_tick(c0 + 26 + 27 * k, k);
    goto(r);
    check("pre_restart_phase", os_phase, 9);
    restart = 1'b1;
    #1;
    check("restart_no_tick", os_tick, 0);
    goto(r + 1);
    restart = 1'b0;
    check("restart_phase0", os_phase, 0);
    x = c0 + 26 + 27 * 16;
    goto(x);
    restart = 1'b1;
    #1;
    check("restart_blocks_tick", os_tick, 0);
    goto(x + 1);
    restart = 1'b0;
    goto(x + 2);
    end_window();

    // freeze with en low
    do_reset(b);
    for (int k = 0; k < 3; k++) push_tick(b + 26 + 27 * k, k);
    goto(b + 101);
    en = 1'b0;
    goto(b + 111);
    check("hold_phase_a", os_phase, 3);
    goto(b + 150);
    check("hold_phase_b", os_phase, 3);
    goto(b + 151);
    en = 1'b1;
    for (int k = 0; k < 3; k++) push_tick(b + 157 + 27 * k, 3 + k);
    goto(b + 157 + 54 + 2);
    end_window();

    // loads while frozen apply immediately
    do_reset(b);
    goto(b + 3);
    div_int  = 7;
    div_load = 1'b1;
    goto(b + 4);
    div_load = 1'b0;
    en       = 1'b0;
    check("pend_shadow", div_pending, 1);
    goto(b + 5);
    check("pend_apply_en0", div_pending, 0);
    div_int  = 5;
    div_load = 1'b1;
    goto(b + 6);
    div_load = 1'b0;
    check("pend_direct", div_pending, 0);
    restart = 1'b1;
    en      = 1'b1;
    goto(b + 7);
    restart = 1'b0;
    c0 = b + 7;
    for (int k = 0; k < 4; k++) push_tick(c0 + 4 + 5 * k, k);
    goto(c0 + 4 + 15 + 2);
    end_window();

    // back-to-back loads, last one (1) clamped to 2
    do_reset(b);
    goto(b + 2);
    div_int  = 4;
    div_load = 1'b1;
    goto(b + 3);
    div_int = 1;
    goto(b + 4);
    div_load = 1'b0;
    check("pend_b2b", div_pending, 1);
    push_tick(b + 26, 0);
    for (int k = 1; k < 20; k++) push_tick(b + 26 + 2 * k, k);
    goto(b + 26 + 38 + 2);
    end_window();

    // asynchronous reset mid-period discards the shadow divisor
    do_reset(b);
    push_tick(b + 26, 0);
    push_tick(b + 53, 1);
    goto(b + 56);
    div_int  = 10;
    div_load = 1'b1;
    goto(b + 57);
    div_load = 1'b0;
    check("pend_before_reset", div_pending, 1);
    goto(b + 60);
    check("pre_reset_phase", os_phase, 2);
    end_window();
    reset = 1'b1;
    #1;
    check("async_phase", os_phase, 0);
    check("async_pending", div_pending, 0);
    check("async_ticks", {os_tick, bit_tick, mid_tick}, 0);
    do_reset(b2);
    for (int k = 0; k < 3; k++) push_tick(b2 + 26 + 27 * k, k);
    goto(b2 + 80 + 2);
    end_window();

`ifdef FRAC_DIV_EN
    // fractional divisor 27 + 2/16
    begin
      int acc, t;
      do_reset(b);
      goto(b + 5);
      div_int  = 27;
      div_frac = 2;
      div_load = 1'b1;
      restart  = 1'b1;
      goto(b + 6);
      div_load = 1'b0;
      restart  = 1'b0;
      c0  = b + 6;
      acc = 0;
      t   = c0 - 1;
      for (int k = 0; k < 16; k++) begin
        t   = t + 27 + ((acc + 2 >= 16) ? 1 : 0);
        acc = (acc + 2) % 16;
        push_tick(t, k);
      end
      check("frac_span", t - (c0 - 1), 434);
      goto(t + 2);
      end_window();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
